// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the variable-latency data memory: turns single-cycle
// load/store requests into the address-change/mem_ready handshake and stalls the pipeline.
`timescale 1ns/1ps

module mem_access_ctrl #(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {StIdle, StWrite, StGuard, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  guard_q, guard_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            guard_q <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                // Address only moves on a real request: any change restarts the memory delay.
                if (req_write) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = 1'b1;
                    state_d = StWrite;
                end else if (req_read) begin
                    addr_d  = req_addr;
                    guard_d = 3'(GUARD_CYCLES);
                    state_d = StGuard;
                end
            end
            StWrite: begin
                we_d    = 1'b0;
                err_d   = 1'b0;
                state_d = StDone;
            end
            StGuard: begin
                // mem_ready may still reflect the previous address here.
                if (guard_q <= 3'd1) begin
                    tmo_d   = '0;
                    state_d = StWait;
                end else begin
                    guard_d = guard_q - 3'd1;
                end
            end
            StWait: begin
                if (mem_ready) begin
                    rdata_d = mem_read_data;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            StIdle:                   stall = req_read | req_write;
            StWrite, StGuard, StWait: stall = 1'b1;
            StDone:                   rsp_valid = 1'b1;
            default:                  stall = 1'b0;
        endcase
    end

    assign rsp_rdata      = rdata_q;
    assign rsp_error      = err_q;
    assign mem_address    = addr_q;
    assign mem_write      = we_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory with address-change delay plus a response
// scoreboard checking data, error flag and completion cycle.
`timescale 1ns/1ps

module tb_mem_access_ctrl;

    localparam int unsigned MEM_DELAY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready)
    );

    // Memory model: ready drops on the edge that sees a new address, rises MEM_DELAY edges later.
    logic [31:0] ram [0:63];
    logic        seeded = 1'b0;
    logic [31:0] last_addr = '0;
    logic        ready_r = 1'b1;
    int unsigned dcnt = 0;
    logic [31:0] rd_data = '0;
    logic        stuck = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
            ram[4] <= 32'hDEADBEEF;
            seeded <= 1'b1;
        end else if (mem_write) begin
            ram[mem_address[7:2]] <= mem_write_data;
        end
        if (mem_address != last_addr) begin
            last_addr <= mem_address;
            ready_r   <= 1'b0;
            dcnt      <= MEM_DELAY;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                ready_r <= 1'b1;
                rd_data <= ram[mem_address[7:2]];
            end
        end
    end

    assign mem_ready     = ready_r & ~stuck;
    assign mem_read_data = rd_data;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            check_eq("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("rsp_cycle", cyc, mon_e.cyc);
                check_eq("rsp_error", 32'(rsp_error), 32'(mon_e.err));
                if (mon_e.is_read) check_eq("rsp_rdata", rsp_rdata, mon_e.rdata);
            end
        end
    end

    // Drives one request in cycle 0, checks stall/mem_write per cycle, drops it after DONE.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int unsigned lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        logic seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        req_read  = rd;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        e.is_read = rd && !wr;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.cyc     = cyc + lat;
        sb.push_back(e);
        for (int k = 0; k <= int'(lat) + 4 && !seen; k++) begin
            @(negedge clk);
            if (k <= int'(lat)) check_eq("stall", 32'(stall), 32'(k < int'(lat)));
            if (wr) check_eq("mem_write", 32'(mem_write), 32'(k == 1));
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("rsp_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_stall"}, 32'(stall), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check_eq({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check_eq({tag, "_mem_address"}, mem_address, 32'd0);
        check_eq({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_cleared("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_stall", 32'(stall), 32'd0);
            check_eq("idle_addr", mem_address, 32'd0);
        end

        do_req(1'b1, 1'b0, 32'h10, 32'h0, 6, 32'hDEADBEEF, 1'b0);

        do_req(1'b0, 1'b1, 32'h20, 32'h12345678, 2, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 4, 32'h12345678, 1'b0);

        // Reset mid-cycle while waiting on the memory.
        @(posedge clk);
        #1;
        req_read = 1'b1;
        req_addr = 32'h40;
        repeat (4) @(negedge clk);
        check_eq("wait_stall", 32'(stall), 32'd1);
        #2;
        rst_n    = 1'b0;
        req_read = 1'b0;
        req_addr = '0;
        #1;
        check_cleared("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 6, 32'hDEADBEEF, 1'b0);

        stuck = 1'b1;
        do_req(1'b1, 1'b0, 32'h44, 32'h0, 18, 32'h0, 1'b1);
        stuck = 1'b0;

        do_req(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 2, 32'h0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_eq("post_both_stall", 32'(stall), 32'd0);
            check_eq("post_both_we", 32'(mem_write), 32'd0);
        end
        check_eq("ram12", ram[12], 32'hA5A5A5A5);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
